pci_reg_access_ctrl: RTL

Upstream master stage for the register target block. It accepts single register requests on a valid/ready request channel and decodes the target from the address. It drives reg_sel/reg_wr toward the register block and waits for that target's bit of pci_ack. It then returns a response, which is either completion data or a timeout error, on a valid/ready response channel.

---
 rtl/pci_reg_access_if.sv | 35 +++
 rtl/pci_reg_access_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pci_reg_access_if.sv
// Request/response and register-block signals for pci_reg_access_ctrl.
// The master modport is the controller's view. The slave modport is the view of the surrounding environment.
interface pci_reg_access_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              reg_sel;
  logic              reg_wr;
  logic [1:0]        reg_tgt;
  logic [ADDR_W-3:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic [3:0]        pci_ack;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, resp_ready, reg_rdata, pci_ack,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output reg_sel, reg_wr, reg_tgt, reg_addr, reg_wdata
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, resp_ready, reg_rdata, pci_ack,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  reg_sel, reg_wr, reg_tgt, reg_addr, reg_wdata
  );
endinterface

// File: rtl/pci_reg_access_ctrl.sv
// Single-outstanding register access master: decodes the target, strobes reg_sel until the target acks
// or a timeout expires, then returns a response on a valid/ready channel.
module pci_reg_access_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  pci_reg_access_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              reg_sel_q, reg_sel_d;
  logic              reg_wr_q, reg_wr_d;
  logic [1:0]        reg_tgt_q, reg_tgt_d;
  logic [ADDR_W-3:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

  // done_q marks that the ack (or the timeout) was sampled. The exit happens on the following edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    reg_sel_d    = reg_sel_q;
    reg_wr_d     = reg_wr_q;
    reg_tgt_d    = reg_tgt_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          reg_sel_d   = 1'b1;
          reg_wr_d    = bus.req_we;
          reg_tgt_d   = bus.req_addr[ADDR_W-1 -: 2];
          reg_addr_d  = bus.req_addr[ADDR_W-3:0];
          reg_wdata_d = bus.req_wdata;
          cnt_d       = '0;
          done_d      = 1'b0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (done_q) begin
          reg_sel_d    = 1'b0;
          reg_wr_d     = 1'b0;
          resp_valid_d = 1'b1;
          done_d       = 1'b0;
          state_d      = RESP;
        end else if (bus.pci_ack[reg_tgt_q]) begin
          // Checked before the timeout so a same-cycle ack wins
          done_d       = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = reg_wr_q ? '0 : bus.reg_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done_d       = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      reg_sel_q    <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_tgt_q    <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      reg_sel_q    <= reg_sel_d;
      reg_wr_q     <= reg_wr_d;
      reg_tgt_q    <= reg_tgt_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.reg_sel    = reg_sel_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_tgt    = reg_tgt_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;

endmodule
